// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: CPU-side bus target.
//   - 2^RAM_AW byte work RAM, mirrored across $0000-$1FFF
//   - joypad serial ports at $4016 (JOY1) and $4017 (JOY2)
//   - open bus (rdata holds) for unmapped reads and for every write cycle
// Optional feature macro: JOYPAD2_EN. When undefined, $4017 reads return $40
// with no side effects and btn_p2 is ignored.
// Ports:
//   clk     system clock shared with the CPU
//   reset   asynchronous active-high reset
//   addr    CPU address, sampled every posedge clk
//   write   1 = write cycle, 0 = read cycle
//   d_out   CPU write data
//   rdata   registered read data (CPU d_in), valid the cycle after the address
//   btn_p1  controller 1 buttons, bit0..7 = A,B,Select,Start,Up,Down,Left,Right
//   btn_p2  controller 2 buttons, same ordering
module cpu_bus_responder #(
    parameter int unsigned RAM_AW   = 11,
    parameter int unsigned JOY_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         addr,
    input  logic                write,
    input  logic [7:0]          d_out,
    output logic [7:0]          rdata,
    input  logic [JOY_BITS-1:0] btn_p1,
    input  logic [JOY_BITS-1:0] btn_p2
);

    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
    localparam logic [15:0] JOY1_ADDR = 16'h4016;
    localparam logic [15:0] JOY2_ADDR = 16'h4017;
    localparam logic [7:0]  JOY_HI    = 8'h40;

    // Address decode
    logic sel_ram_c;
    logic sel_j1_c;
    logic sel_j2_c;
    assign sel_ram_c = (addr[15:13] == 3'b000);
    assign sel_j1_c  = (addr == JOY1_ADDR);
    assign sel_j2_c  = (addr == JOY2_ADDR);

    logic                strobe;
    logic [JOY_BITS-1:0] sh1;
    logic                j1_bit_c;
    logic [7:0]          j2_data_c;

    // While strobing, the port reflects the live A button rather than the latched copy
    assign j1_bit_c = strobe ? btn_p1[0] : sh1[0];

`ifdef JOYPAD2_EN
    logic [JOY_BITS-1:0] sh2;
    logic                j2_bit_c;
    assign j2_bit_c  = strobe ? btn_p2[0] : sh2[0];
    assign j2_data_c = {JOY_HI[7:1], j2_bit_c};

    // Controller 2 shift register: reload while strobing, shift 1s in on each read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh2 <= '0;
        end else if (strobe) begin
            sh2 <= btn_p2;
        end else if (!write && sel_j2_c) begin
            sh2 <= {1'b1, sh2[JOY_BITS-1:1]};
        end
    end
`else
    logic unused_btn_p2;
    assign unused_btn_p2 = ^btn_p2;
    assign j2_data_c     = JOY_HI;
`endif

    // Work RAM; no reset, and a write coinciding with reset is dropped
    logic [7:0] ram [RAM_DEPTH];
    logic       ram_we_c;
    assign ram_we_c = write & sel_ram_c & ~reset;

    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            ram[addr[RAM_AW-1:0]] <= d_out;
        end
    end

    // Strobe register, written by any write to $4016
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe <= 1'b0;
        end else if (write && sel_j1_c) begin
            strobe <= d_out[0];
        end
    end

    // Controller 1 shift register: reload while strobing, shift 1s in on each read.
    // The old strobe value governs, so clearing strobe still reloads on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh1 <= '0;
        end else if (strobe) begin
            sh1 <= btn_p1;
        end else if (!write && sel_j1_c) begin
            sh1 <= {1'b1, sh1[JOY_BITS-1:1]};
        end
    end

    // Read data register; holds on writes and unmapped reads (open bus)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= 8'h00;
        end else if (!write) begin
            if (sel_ram_c) begin
                rdata <= ram[addr[RAM_AW-1:0]];
            end else if (sel_j1_c) begin
                rdata <= {JOY_HI[7:1], j1_bit_c};
            end else if (sel_j2_c) begin
                rdata <= j2_data_c;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

    localparam int unsigned RAM_SIZE = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic        write;
    logic [7:0]  d_out;
    logic [7:0]  rdata;
    logic [7:0]  btn_p1;
    logic [7:0]  btn_p2;

    always #5 clk = ~clk;

    cpu_bus_responder dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .write  (write),
        .d_out  (d_out),
        .rdata  (rdata),
        .btn_p1 (btn_p1),
        .btn_p2 (btn_p2)
    );

    typedef struct {
        logic [7:0] v;
        int         id;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_id  = 0;

    // Reference model: byte array memory, latched button snapshots plus a count of bits consumed
    logic [7:0] ram_m [RAM_SIZE];
    logic [7:0] rd_m;
    bit         strobe_m;
    logic [7:0] snap1, snap2;
    int         cnt1, cnt2;

    function automatic logic joy_bit(input logic [7:0] snap, input int cnt);
        return (cnt < 8) ? snap[cnt] : 1'b1;
    endfunction

    task automatic model_edge();
        logic [7:0] nrd;
        bit         old_strobe;
        if (reset) begin
            rd_m     = 8'h00;
            strobe_m = 1'b0;
            snap1    = 8'h00;
            snap2    = 8'h00;
            cnt1     = 0;
            cnt2     = 0;
        end else begin
            old_strobe = strobe_m;
            nrd        = rd_m;
            if (!write) begin
                if (addr < 16'h2000)
                    nrd = ram_m[int'(addr) % RAM_SIZE];
                else if (addr == 16'h4016)
                    nrd = 8'h40 + 8'(old_strobe ? btn_p1[0] : joy_bit(snap1, cnt1));
                else if (addr == 16'h4017) begin
`ifdef JOYPAD2_EN
                    nrd = 8'h40 + 8'(old_strobe ? btn_p2[0] : joy_bit(snap2, cnt2));
`else
                    nrd = 8'h40;
`endif
                end
            end
            if (old_strobe) begin
                snap1 = btn_p1; cnt1 = 0;
                snap2 = btn_p2; cnt2 = 0;
            end else if (!write && addr == 16'h4016) begin
                if (cnt1 < 8) cnt1++;
            end else if (!write && addr == 16'h4017) begin
                if (cnt2 < 8) cnt2++;
            end
            if (write && addr < 16'h2000) ram_m[int'(addr) % RAM_SIZE] = d_out;
            if (write && addr == 16'h4016) strobe_m = d_out[0];
            rd_m = nrd;
        end
        q.push_back('{v: rd_m, id: cyc_id});
        cyc_id++;
    endtask

    // One bus cycle: drive, let the edge happen, update the model, move off the edge
    task automatic cycle(input logic [15:0] a, input logic w, input logic [7:0] d);
        addr  = a;
        write = w;
        d_out = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Reset asserted mid-cycle with a RAM write pending across the edge
    task automatic reset_mid(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        #1;
        addr  = a;
        write = 1'b1;
        d_out = d;
        reset = 1'b1;
        #1;
        n_tests++;
        if (rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async: rdata=%h expected 00", rdata);
        end
        @(posedge clk);
        model_edge();
        #1;
        reset = 1'b0;
    endtask

    // Monitor: one expected rdata per bus cycle, compared away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if (rdata !== e.v) begin
                    n_fail++;
                    $display("FAIL rdata cycle %0d: got %h expected %h", e.id, rdata, e.v);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a;
        int          k;

        reset  = 1'b1;
        addr   = 16'h0000;
        write  = 1'b0;
        d_out  = 8'h00;
        btn_p1 = 8'h00;
        btn_p2 = 8'h00;
        cycle(16'h0000, 1'b0, 8'h00);
        cycle(16'h0000, 1'b0, 8'h00);
        reset = 1'b0;

        // Fill the RAM through all four mirrors so every later read is defined
        for (int i = 0; i < int'(RAM_SIZE); i++)
            cycle(16'(i + int'(RAM_SIZE) * (i % 4)), 1'b1, 8'($urandom));

        // RAM mirror
        cycle(16'h0123, 1'b1, 8'h5A);
        cycle(16'h0923, 1'b0, 8'h00);
        cycle(16'h1123, 1'b0, 8'h00);
        cycle(16'h1923, 1'b0, 8'h00);

        // Read-after-write, then open bus holds
        cycle(16'h07FF, 1'b1, 8'hA5);
        cycle(16'h07FF, 1'b0, 8'h00);
        cycle(16'h5000, 1'b0, 8'h00);

        // Joypad serial: 8 button bits then 1s
        btn_p1 = 8'b1000_0101;
        cycle(16'h4016, 1'b1, 8'h01);
        cycle(16'h4016, 1'b1, 8'h00);
        btn_p1 = 8'h00;
        for (int i = 0; i < 10; i++) cycle(16'h4016, 1'b0, 8'h00);

        // Strobe held: live A button, no shifting
        cycle(16'h4016, 1'b1, 8'h01);
        btn_p1 = 8'h01; cycle(16'h4016, 1'b0, 8'h00);
        btn_p1 = 8'h00; cycle(16'h4016, 1'b0, 8'h00);
        btn_p1 = 8'h01; cycle(16'h4016, 1'b0, 8'h00);
        btn_p1 = 8'h6A;
        cycle(16'h4016, 1'b1, 8'h00);
        for (int i = 0; i < 9; i++) cycle(16'h4016, 1'b0, 8'h00);

        // Open bus over a known value, then write to $4017 ignored
        cycle(16'h0000, 1'b1, 8'h33);
        cycle(16'h0000, 1'b0, 8'h00);
        cycle(16'h5000, 1'b0, 8'h00);
        cycle(16'h4017, 1'b1, 8'h01);
        cycle(16'hFFFF, 1'b0, 8'h00);

        // Reset mid-cycle: write dropped, joypads cleared
        reset_mid(16'h0200, 8'hEE);
        cycle(16'h0200, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) cycle(16'h4016, 1'b0, 8'h00);

        // Port 2 with all buttons pressed but never strobed
        btn_p2 = 8'hFF;
        cycle(16'h4017, 1'b0, 8'h00);
        cycle(16'h4017, 1'b0, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) btn_p1 = 8'($urandom);
            if ($urandom_range(0, 7) == 0) btn_p2 = 8'($urandom);
            k = int'($urandom_range(0, 9));
            if (k < 4)       a = 16'($urandom_range(0, 16'h1FFF));
            else if (k < 7)  a = 16'h4016;
            else if (k < 8)  a = 16'h4017;
            else begin
                a = 16'($urandom_range(16'h2000, 16'hFFFF));
                if (a == 16'h4016 || a == 16'h4017) a = 16'h4018;
            end
            if (i % 700 == 699)
                reset_mid(16'($urandom_range(0, 16'h1FFF)), 8'($urandom));
            else
                cycle(a, ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        addr  = 16'h5000;
        write = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Bus target on the CPU side of the system. It answers the CPU's addr/write/d_out bus cycles and drives the CPU's d_in.
- Contains the 2 KB internal work RAM, mirrored across $0000-$1FFF.
- Contains the joypad serial ports at $4016/$4017.
- Provides open-bus behaviour for every unmapped address.

Parameters:
- RAM_AW, 11, work-RAM address width. Depth is 2^RAM_AW bytes; the RAM is mirrored every 2^RAM_AW bytes inside $0000-$1FFF.
- JOY_BITS, 8, number of buttons per controller shifted out serially.

Ports:
- clk  in  1  system clock, shared with the CPU.
- reset  in  1  asynchronous, active-high reset.
- addr  in  16  CPU address bus.
- write  in  1  CPU write strobe; 1 = write cycle, 0 = read cycle.
- d_out  in  8  CPU write data.
- rdata  out  8  read data, connected to the CPU's d_in.
- btn_p1  in  JOY_BITS  controller 1 buttons, active-high, bit0..7 = A,B,Select,Start,Up,Down,Left,Right.
- btn_p2  in  JOY_BITS  controller 2 buttons, same ordering.

Behaviour:
- Every cycle is a bus cycle: addr/write/d_out are sampled at each posedge clk. There is no idle qualifier.
- Read latency is 1: for addr presented in cycle N with write=0, rdata is valid throughout cycle N+1 (registered output).
- Write cycle: RAM and register updates take effect at the sampling edge, and rdata holds its previous value.
- Decode (exclusive):
  - RAM: addr[15:13]==3'b000; index = addr[RAM_AW-1:0].
  - JOY1: addr==$4016.
  - JOY2: addr==$4017.
  - Everything else is unmapped.
- RAM read-after-write: a read of the same location in the cycle after the write returns the new byte. No bypass hazard exists, because the bus is single-ported.
- RAM contents are not reset. Simulation reads of unwritten locations return X.
- Joypad strobe register:
  - 1-bit strobe register, written by any write to $4016 with strobe <= d_out[0].
  - Writes to $4017 are ignored.
- Per controller, JOY_BITS-wide shift register shN:
  - While strobe=1: shN <= btnN every cycle, so reads return the live A button.
  - While strobe=0: a read of the port returns shN[0] in rdata bit0. In the same edge, shN <= {1'b1, shN[JOY_BITS-1:1]}.
  - After JOY_BITS reads every further read returns 1 until the next reload.
- Joypad read data = {3'b010, 4'b0000, bit} ($40 or $41).
- Each read cycle addressing a port shifts exactly once. A CPU holding the address for k cycles consumes k bits.
- A write to $4016 with d_out[0]=0 while strobe=1 does the following:
  - At that edge, shN reloads from btnN (the strobe=1 rule still applies).
  - From the next cycle on, shifting is enabled.
- Unmapped read: rdata holds its previous value (open bus); no side effects.
- Reset (async, any cycle, including mid-shift or mid-write):
  - rdata=8'h00, strobe=0, sh1=sh2=8'h00.
  - The RAM array is untouched; a write in the cycle reset asserts is dropped.
- Release: the first posedge with reset=0 is a normal bus cycle.

Optional Feature:
- Macro: JOYPAD2_EN.
- Defined: $4017 behaves as JOY2 as described above.
- Undefined:
  - sh2 is not instantiated and btn_p2 is unused.
  - A read of $4017 returns $40 with no side effects.
  - The port list is unchanged.

Test Plan:
- RAM + mirror: write $5A to $0123, then read $0923, $1123 and $1923. Each returns $5A one cycle after the addr cycle.
- Read-after-write: write $A5 to $07FF in cycle N and read $07FF in cycle N+1. rdata=$A5 in cycle N+2.
- Joypad serial:
  - btn_p1=8'b1000_0101; write $01 then $00 to $4016; read $4016 ten times.
  - Required bit0 sequence: 1,0,1,0,0,0,0,1,1,1, with rdata $41/$40 and bits 7:1 = $20.
- Strobe held: write $01 to $4016 and read $4016 three times while toggling btn_p1[0] 1,0,1. rdata = $41,$40,$41, and no shifting occurs.
- Open bus + reset:
  - Read $0000 (=$33), then read $5000: rdata stays $33.
  - Assert reset mid-cycle: rdata goes to $00 immediately; strobe=0 and sh1 reads $40 before any strobe.
- JOYPAD2_EN undefined: btn_p2=8'hFF; read $4017 twice. Both reads return $40.
